// File: rtl/sysarray_pkg.sv
// Shared constants and state encoding for the 3x3 systolic array sequencer.
package sysarray_pkg;

  localparam int unsigned N         = 3;
  localparam int unsigned FEED_CYC  = 3 * N - 2;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned DEF_A_W   = 8;
  localparam int unsigned DEF_B_W   = 8;
  localparam int unsigned DEF_ACC_W = 18;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    FEED = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/sysarray_skew.sv
// Diagonal wavefront generator: row i / column j lag the feed count by i / j cycles.
module sysarray_skew
  import sysarray_pkg::*;
#(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W
) (
  input  logic signed [A_W-1:0] a_q  [0:8],
  input  logic signed [B_W-1:0] b_q  [0:8],
  input  logic [CNT_W-1:0]      cnt,
  input  logic                  en,
  output logic signed [A_W-1:0] left [0:2],
  output logic signed [B_W-1:0] top  [0:2]
);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      left[i] = '0;
      top[i]  = '0;
      if (en && (int'(cnt) >= i) && (int'(cnt) - i <= 2)) begin
        left[i] = a_q[3 * i + int'(cnt) - i];
        top[i]  = b_q[3 * (int'(cnt) - i) + i];
      end
    end
  end

endmodule

// File: rtl/sysarray_ctrl.sv
// Job sequencer for the 3x3 output-stationary systolic array: clear, skewed feed, drain, capture.
module sysarray_ctrl
  import sysarray_pkg::*;
#(
  parameter int unsigned A_W   = DEF_A_W,
  parameter int unsigned B_W   = DEF_B_W,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   a_mat    [0:8],
  input  logic signed [B_W-1:0]   b_mat    [0:8],
  output logic                    arr_clr,
  output logic signed [A_W-1:0]   arr_left [0:2],
  output logic signed [B_W-1:0]   arr_top  [0:2],
  input  logic signed [ACC_W-1:0] arr_out  [0:8],
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res      [0:8],
  output logic                    busy
);

  ctrl_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic accept;
  logic signed [A_W-1:0] a_q [0:8];
  logic signed [B_W-1:0] b_q [0:8];
  logic signed [A_W-1:0] left_d [0:2];
  logic signed [B_W-1:0] top_d  [0:2];

  // Array-facing outputs are registered from next-state so they line up with the state they belong to.
  sysarray_skew #(.A_W(A_W), .B_W(B_W)) u_skew (
    .a_q  (a_q),
    .b_q  (b_q),
    .cnt  (cnt_d),
    .en   (state_d == FEED),
    .left (left_d),
    .top  (top_d)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        if (cnt == CNT_W'(FEED_CYC - 1)) begin
          cnt_d   = '0;
          state_d = CAPT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      CAPT: state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      arr_clr   <= 1'b0;
      res_valid <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        res[k] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        arr_left[i] <= '0;
        arr_top[i]  <= '0;
      end
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      arr_clr   <= (state_d == CLR);
      res_valid <= (state_d == DONE);
      arr_left  <= left_d;
      arr_top   <= top_d;
      if (accept) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      if (state == CAPT) res <= arr_out;
    end
  end

endmodule

// File: tb/tb_sysarray_ctrl.sv
// Directed self-checking bench for sysarray_ctrl driving a behavioural 3x3 array model.
module tb_sysarray_ctrl;

  logic clk = 1'b0;
  logic rst, arr_rst;
  logic in_valid, in_ready, arr_clr, res_valid, res_ready, busy;
  logic signed [7:0]  a_mat    [0:8];
  logic signed [7:0]  b_mat    [0:8];
  logic signed [7:0]  arr_left [0:2];
  logic signed [7:0]  arr_top  [0:2];
  logic signed [17:0] arr_out  [0:8];
  logic signed [17:0] res      [0:8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_res [0:8];

  always #5 clk = ~clk;

  sysarray_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_clr(arr_clr), .arr_left(arr_left),
    .arr_top(arr_top), .arr_out(arr_out), .res_valid(res_valid),
    .res_ready(res_ready), .res(res), .busy(busy)
  );

  // Array model: PE(i,j) multiplies its incoming a/b and forwards them right/down one cycle later.
  logic signed [7:0]  pa  [0:2][0:2];
  logic signed [7:0]  pb  [0:2][0:2];
  logic signed [17:0] acc [0:8];

  always @(posedge clk) begin : array_model
    logic signed [7:0] ain, bin;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ain = (j == 0) ? arr_left[i] : pa[i][j-1];
        bin = (i == 0) ? arr_top[j]  : pb[i-1][j];
        if (!arr_rst) begin
          pa[i][j] <= '0; pb[i][j] <= '0; acc[3*i+j] <= '0;
        end else begin
          pa[i][j] <= ain;
          pb[i][j] <= bin;
          if (arr_clr) acc[3*i+j] <= '0;
          else acc[3*i+j] <= acc[3*i+j] + 18'(32'(ain) * 32'(bin));
        end
      end
    end
  end

  always_comb for (int k = 0; k < 9; k++) arr_out[k] = acc[k];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_res(input string tag);
    for (int k = 0; k < 9; k++) chk($sformatf("%s res[%0d]", tag, k), res[k], exp_res[k]);
  endtask

  task automatic accept_job();
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, cyc, 10);
  endtask

  initial begin
    rst = 1'b0; arr_rst = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin a_mat[k] = '0; b_mat[k] = '0; end
    tick(); tick();
    chk("rst in_ready", in_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst arr_clr", arr_clr, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst res0", res[0], 0);
    rst = 1'b1; arr_rst = 1'b1;
    tick();

    // Job 1: identity x [1..9]
    for (int k = 0; k < 9; k++) begin a_mat[k] = 8'((k % 4 == 0) ? 1 : 0); b_mat[k] = 8'(k + 1); end
    exp_res = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    accept_job();
    chk("j1 clr", arr_clr, 1);
    chk("j1 busy", busy, 1);
    chk("j1 in_ready", in_ready, 0);
    wait_valid("j1 latency");
    chk_res("j1");
    tick();
    chk("j1 valid one cycle", res_valid, 0);
    chk("j1 ready back", in_ready, 1);
    chk("j1 idle busy", busy, 0);

    // Job 2: all -128 x all -128
    for (int k = 0; k < 9; k++) begin a_mat[k] = -8'sd128; b_mat[k] = -8'sd128; end
    for (int k = 0; k < 9; k++) exp_res[k] = 49152;
    accept_job();
    wait_valid("j2 latency");
    chk_res("j2");
    tick();

    // Job 3: all -128 x all 127
    for (int k = 0; k < 9; k++) begin a_mat[k] = -8'sd128; b_mat[k] = 8'sd127; end
    for (int k = 0; k < 9; k++) exp_res[k] = -48768;
    accept_job();
    wait_valid("j3 latency");
    chk_res("j3");
    tick();

    // Job 4: [1..9] x [9..1], skew checks, ignored in_valid, backpressure
    for (int k = 0; k < 9; k++) begin a_mat[k] = 8'(k + 1); b_mat[k] = 8'(9 - k); end
    exp_res = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    res_ready = 1'b0;
    accept_job();
    chk("j4 clr c1", arr_clr, 1);
    tick();
    chk("j4 clr c2", arr_clr, 0);
    chk("j4 cnt0 left0", arr_left[0], 1);
    chk("j4 cnt0 top0", arr_top[0], 9);
    chk("j4 cnt0 left1", arr_left[1], 0);
    tick();
    tick();
    chk("j4 cnt2 left0", arr_left[0], 3);
    chk("j4 cnt2 left1", arr_left[1], 5);
    chk("j4 cnt2 left2", arr_left[2], 7);
    chk("j4 cnt2 top0", arr_top[0], 3);
    chk("j4 cnt2 top1", arr_top[1], 5);
    chk("j4 cnt2 top2", arr_top[2], 7);
    chk("j4 cnt2 clr", arr_clr, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin a_mat[k] = 8'sd100; b_mat[k] = 8'sd100; end
    tick();
    in_valid = 1'b0;
    chk("j4 busy ready", in_ready, 0);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("j4 cnt5 left%0d", i), arr_left[i], 0);
      chk($sformatf("j4 cnt5 top%0d", i), arr_top[i], 0);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("j4 cnt6 left%0d", i), arr_left[i], 0);
      chk($sformatf("j4 cnt6 top%0d", i), arr_top[i], 0);
    end
    tick();
    chk("j4 capt valid", res_valid, 0);
    wait_valid("j4 latency");
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("j4 hold valid", res_valid, 1);
      chk("j4 hold in_ready", in_ready, 0);
      chk("j4 hold res0", res[0], 30);
      chk("j4 hold res8", res[8], 90);
    end
    chk_res("j4");
    res_ready = 1'b1;
    tick();
    chk("j4 released valid", res_valid, 0);
    chk("j4 released ready", in_ready, 1);

    // Job 5: reset mid-feed, then job 6 on dirty accumulators
    for (int k = 0; k < 9; k++) begin a_mat[k] = 8'sd1; b_mat[k] = 8'sd1; end
    accept_job();
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst busy", busy, 0);
    chk("mid rst clr", arr_clr, 0);
    chk("mid rst valid", res_valid, 0);
    chk("mid rst res8", res[8], 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid rst left%0d", i), arr_left[i], 0);
      chk($sformatf("mid rst top%0d", i), arr_top[i], 0);
    end
    for (int k = 0; k < 9; k++) begin a_mat[k] = 8'(k + 1); b_mat[k] = 8'((k % 4 == 0) ? 1 : 0); end
    exp_res = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    accept_job();
    wait_valid("j6 latency");
    chk_res("j6");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sysarray_ctrl.md
# sysarray_ctrl

Sequencer for the 3x3 output-stationary systolic array (`sysarray`). It accepts one A/B operand pair through a valid/ready handshake and clears the array accumulators. It then drives the diagonally skewed operand wavefronts onto the array's `left`/`top` ports, waits for the pipeline to drain, and captures the nine accumulators. The result is presented on a valid/ready output. It sits between the matrix-job source and the array instance.

## Interface
- `A_W`, 8, signed element width of A (row operand, `left`)
- `B_W`, 8, signed element width of B (column operand, `top`)
- `ACC_W`, 18, accumulator/result width; must equal array `ACC_W`

Ports:
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset, synchronous, active-low (`rst`==0 resets on the rising edge of `clk`)
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  controller can accept a pair
- `a_mat[0:8]`  in  A_W each, signed  A, row-major (`a_mat[3*i+k]` = A[i][k])
- `b_mat[0:8]`  in  B_W each, signed  B, row-major (`b_mat[3*k+j]` = B[k][j])
- `arr_clr`  out  1  to array `clr`
- `arr_left[0:2]`  out  A_W each, signed  to array `left`
- `arr_top[0:2]`  out  B_W each, signed  to array `top`
- `arr_out[0:8]`  in  ACC_W each, signed  from array `out` (`out[3*i+j]` = C[i][j])
- `res_valid`  out  1  result valid
- `res_ready`  in  1  consumer accepts result
- `res[0:8]`  out  ACC_W each, signed  captured C = A·B, row-major
- `busy`  out  1  high in every state except IDLE

## Operation
- Array contract: each PE registers `a`/`b` pass-through with one cycle latency. On each edge it does `acc <= acc + a*b`. `clr` is synchronous and zeroes `acc` with priority over accumulation. Array reset is driven separately at top level.
- The controller latches `a_mat`/`b_mat` into internal registers on acceptance (`in_valid && in_ready`). Inputs may change afterwards.
- FSM states IDLE, CLR, FEED, CAPT, DONE:
  - IDLE: `in_ready`=1. On accept, go to CLR.
  - CLR: 1 cycle with `arr_clr`=1 and all `arr_left`/`arr_top` = 0. Go to FEED with `cnt`=0.
  - FEED: 7 cycles, `cnt` = 0..6.
    - `arr_left[i]` = A[i][cnt−i] if 0 ≤ cnt−i ≤ 2, else 0.
    - `arr_top[j]` = B[cnt−j][j] if 0 ≤ cnt−j ≤ 2, else 0.
    - Cycles `cnt`=5,6 inject zeros only (drain).
    - At `cnt`=6, go to CAPT.
  - CAPT: 1 cycle with zero inputs. `res` <= `arr_out` on the edge. Go to DONE.
  - DONE: `res_valid`=1, `res` stable. When `res_ready`=1, go to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` in any other state is ignored and the new pair is not latched.
- Arithmetic: no saturation or truncation by the controller; `res` is a verbatim copy of `arr_out`. Worst case 3·(−128·−128) = 49152 fits signed 17 bits. `ACC_W` ≥ A_W+B_W+2 is required by design.
- `arr_clr`, `arr_left`, `arr_top`, `in_ready`, `res_valid` and `busy` are functions of registered state only. There is no combinational path from inputs.

## Timing
- Accept on edge t.
  - CLR occupies cycle t+1.
  - FEED occupies t+2..t+8.
  - CAPT occupies t+9; `arr_out` is final there, because the last product reaches PE(2,2) at t+8.
  - `res_valid` rises at t+10.
- Job latency is 10 cycles from accept to `res_valid`. Minimum spacing between accepts is 11 cycles; the earliest next accept is the cycle after `res_valid && res_ready`.
- Reset values: state=IDLE, `cnt`=0; `in_ready`=1, `busy`=0, `arr_clr`=0, `arr_left`/`arr_top`=0, `res_valid`=0, `res`=0, operand registers=0.
- Reset mid-job (any state): on the next edge, return to IDLE with all outputs at reset values and drop the job. The next job's CLR guarantees clean accumulators.
- `res_ready` held high before DONE has no effect. DONE lasts at least 1 cycle.
- In DONE, `res` holds indefinitely while `res_ready`=0.

## Structure
- Shared package `sysarray_pkg`:
  - `N`=3
  - `FEED_CYC`=3N−2=7
  - state enum `ctrl_state_t` {IDLE, CLR, FEED, CAPT, DONE}
  - default width constants A_W, B_W, ACC_W
- One natural sub-module: `sysarray_skew`, combinational. It maps the latched A/B matrices plus `cnt` and a feed-enable to `arr_left`/`arr_top`. It has one instance.
- A top-level wrapper connects `sysarray_ctrl` to `sysarray`.

## Test plan
- A = identity, B = [1..9] row-major, `res_ready`=1 → `res` = [1..9], `res_valid` at accept+10 for exactly 1 cycle.
- All A = −128, all B = −128 → every `res` = 49152. With A = −128, B = 127 → every `res` = −48768.
- A = [1..9], B = [9..1], `res_ready`=0 for 20 cycles → `res` = [30,24,18,84,69,54,138,114,90] held stable, `in_ready`=0 throughout. Accept is possible the cycle after `res_ready`=1.
- Skew check for the same job at FEED `cnt`=2: `arr_left` = {A[0][2],A[1][1],A[2][0]} = {3,5,7}, `arr_top` = {B[2][0],B[1][1],B[0][2]} = {3,5,7}. At `cnt`=5,6 all zero. `arr_clr`=1 only at t+1.
- `in_valid` pulsed with different data at t+4 → ignored, and the result equals the first job's.
- `rst`=0 for 1 cycle at t+5, then a new job → outputs at reset values the cycle after reset. The new job's result is correct and uncontaminated by the partial sums.
